// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
// Queue entries carry the prediction and both candidate fetch addresses.
package branch_resolve_ctrl_pkg;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic        pred;
        logic [31:0] target;
        logic [31:0] fallthru;
    } br_entry_t;

endpackage

// File: rtl/branch_resolve_ctrl_fifo.sv
// In-order queue of in-flight branches; clear wins over push/pop.
// Push at full is only honoured when paired with a pop.
module branch_fifo
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves the oldest in-flight branch against MEM outcome, trains the
// predictor, and issues a one-cycle flush/redirect on mispredict.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic             dec_pred,
    input  logic [31:0]      dec_target,
    input  logic [31:0]      dec_fallthru,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             err_ovf,
    output logic             err_unf
);
    logic [0:0] state;
    br_entry_t  head, wentry;
    logic       run, accept, mispred, unf, enq, pop, ovf;

    assign wentry = '{pred: dec_pred, target: dec_target, fallthru: dec_fallthru};

    assign run     = (state == ST_RUN);
    assign accept  = run & res_valid & ~empty;
    assign mispred = accept & (head.pred != res_taken);
    assign unf     = run & res_valid & empty;
    // Decode traffic during the mispredict cycle and the flush cycle is squashed.
    assign enq     = run & dec_valid & ~mispred;
    assign pop     = accept & ~mispred;
    assign ovf     = enq & full & ~pop;

    // Derived from state so an async reset drops it without a clock edge.
    assign flush = (state == ST_FLUSH);

    branch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mispred),
        .push  (enq),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            upd_valid      <= 1'b0;
            upd_taken      <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            err_ovf        <= 1'b0;
            err_unf        <= 1'b0;
        end else begin
            state     <= mispred ? ST_FLUSH : ST_RUN;
            upd_valid <= accept;
            upd_taken <= accept & res_taken;
            if (mispred) begin
                redirect_pc <= res_taken ? head.target : head.fallthru;
                if (mispredict_cnt != '1)
                    mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
            if (ovf) err_ovf <= 1'b1;
            if (unf) err_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed checks for branch_resolve_ctrl; a CNT_W=2 twin shares the stimulus
// so counter saturation is observed alongside the full-width counter.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_pred, res_valid, res_taken;
    logic [31:0] dec_target, dec_fallthru;
    logic        upd_valid, upd_taken, flush, full, empty, err_ovf, err_unf;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;
    logic        upd_valid2, upd_taken2, flush2, full2, empty2, err_ovf2, err_unf2;
    logic [31:0] redirect_pc2;
    logic [1:0]  mispredict_cnt2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_pred(dec_pred),
        .dec_target(dec_target), .dec_fallthru(dec_fallthru),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .flush(flush),
        .redirect_pc(redirect_pc), .full(full), .empty(empty),
        .mispredict_cnt(mispredict_cnt), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    branch_resolve_ctrl #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_pred(dec_pred),
        .dec_target(dec_target), .dec_fallthru(dec_fallthru),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid2), .upd_taken(upd_taken2), .flush(flush2),
        .redirect_pc(redirect_pc2), .full(full2), .empty(empty2),
        .mispredict_cnt(mispredict_cnt2), .err_ovf(err_ovf2), .err_unf(err_unf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_pred = 0; dec_target = '0; dec_fallthru = '0;
        res_valid = 0; res_taken = 0;
    endtask

    task automatic enq(input logic p, input logic [31:0] t, input logic [31:0] f);
        dec_valid = 1; dec_pred = p; dec_target = t; dec_fallthru = f;
    endtask

    // Enqueue a predicted-taken branch, resolve it not-taken, ride out the flush.
    task automatic mispredict(input logic [31:0] f);
        idle(); enq(1'b1, 32'h900, f); tick();
        idle(); res_valid = 1; res_taken = 0; tick();
        chk("mp_flush", {31'b0, flush}, 32'd1);
        chk("mp_redirect", redirect_pc, f);
        idle(); tick();
    endtask

    initial begin
        rst_n = 0;
        idle();
        #12;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_upd", {31'b0, upd_valid}, 32'd0);
        chk("rst_cnt", {16'b0, mispredict_cnt}, 32'd0);
        chk("rst_errs", {30'b0, err_ovf, err_unf}, 32'd0);
        #10 rst_n = 1;
        tick();

        // Correctly predicted taken branch
        enq(1'b1, 32'h100, 32'h44); tick();
        chk("t1_nonempty", {31'b0, empty}, 32'd0);
        idle(); res_valid = 1; res_taken = 1; tick();
        chk("t1_upd_valid", {31'b0, upd_valid}, 32'd1);
        chk("t1_upd_taken", {31'b0, upd_taken}, 32'd1);
        chk("t1_flush", {31'b0, flush}, 32'd0);
        chk("t1_cnt", {16'b0, mispredict_cnt}, 32'd0);
        chk("t1_empty", {31'b0, empty}, 32'd1);
        idle(); tick();
        chk("t1_strobe_end", {31'b0, upd_valid}, 32'd0);

        // Predicted taken, actually not taken; decode in N and N+1 squashed
        enq(1'b1, 32'h200, 32'h84); tick();
        res_valid = 1; res_taken = 0; enq(1'b1, 32'hAAA, 32'hBBB); tick();
        chk("t2_flush", {31'b0, flush}, 32'd1);
        chk("t2_redirect", redirect_pc, 32'h84);
        chk("t2_cnt", {16'b0, mispredict_cnt}, 32'd1);
        chk("t2_empty", {31'b0, empty}, 32'd1);
        chk("t2_upd", {30'b0, upd_valid, upd_taken}, 32'b10);
        res_valid = 1; res_taken = 1; enq(1'b1, 32'hCCC, 32'hDDD); tick();
        chk("t2_flush_end", {31'b0, flush}, 32'd0);
        chk("t2_discard", {31'b0, empty}, 32'd1);
        chk("t2_flush_res_ignored", {30'b0, upd_valid, err_unf}, 32'd0);
        idle(); tick();

        // Predicted not taken, actually taken -> redirect to target
        enq(1'b0, 32'h300, 32'h10); tick();
        idle(); res_valid = 1; res_taken = 1; tick();
        chk("t3_redirect", redirect_pc, 32'h300);
        chk("t3_cnt", {16'b0, mispredict_cnt}, 32'd2);
        idle(); tick();

        // Fill, overflow, then push+pop at full
        for (int i = 1; i <= 4; i++) begin
            enq(1'b1, 32'h400 + i, 32'h500 + i); tick();
        end
        chk("t4_full", {31'b0, full}, 32'd1);
        chk("t4_no_ovf_yet", {31'b0, err_ovf}, 32'd0);
        enq(1'b1, 32'h405, 32'h505); tick();
        chk("t4_ovf", {31'b0, err_ovf}, 32'd1);
        chk("t4_full_after_ovf", {31'b0, full}, 32'd1);
        enq(1'b1, 32'h406, 32'h506); res_valid = 1; res_taken = 1; tick();
        chk("t4_pushpop_full", {31'b0, full}, 32'd1);
        chk("t4_ovf_sticky", {31'b0, err_ovf}, 32'd1);
        chk("t4_pushpop_upd", {31'b0, upd_valid}, 32'd1);
        idle(); res_valid = 1; res_taken = 1;
        tick(); tick(); tick();
        chk("t4_three_left_one", {31'b0, empty}, 32'd0);
        res_taken = 0; tick();
        chk("t4_order_redirect", redirect_pc, 32'h506);
        chk("t4_clear", {31'b0, empty}, 32'd1);
        chk("t4_cnt", {16'b0, mispredict_cnt}, 32'd3);
        idle(); tick();

        // Resolve with empty queue
        res_valid = 1; res_taken = 1; tick();
        chk("t5_unf", {31'b0, err_unf}, 32'd1);
        chk("t5_no_upd", {31'b0, upd_valid}, 32'd0);
        chk("t5_no_flush", {31'b0, flush}, 32'd0);
        idle(); tick();

        // Saturation on the narrow counter
        mispredict(32'h604);
        mispredict(32'h605);
        chk("t6_cnt_wide", {16'b0, mispredict_cnt}, 32'd5);
        chk("t6_cnt_sat", {30'b0, mispredict_cnt2}, 32'd3);
        chk("t6_errs_sticky", {30'b0, err_ovf, err_unf}, 32'b11);

        // Async reset in the middle of a flush
        enq(1'b1, 32'h700, 32'h704); tick();
        idle(); res_valid = 1; res_taken = 0; tick();
        chk("t7_flush_before", {31'b0, flush}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("t7_flush_async", {31'b0, flush}, 32'd0);
        chk("t7_upd", {30'b0, upd_valid, upd_taken}, 32'd0);
        chk("t7_redirect", redirect_pc, 32'd0);
        chk("t7_cnt", {16'b0, mispredict_cnt}, 32'd0);
        chk("t7_errs", {30'b0, err_ovf, err_unf}, 32'd0);
        chk("t7_status", {30'b0, full, empty}, 32'b01);
        idle();
        #3 rst_n = 1;
        tick();
        chk("t7_idle_run", {29'b0, flush, upd_valid, empty}, 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter DEPTH, 4, in-flight branch queue entries; power of two, 2..16.
REQ-002 Parameter CNT_W, 16, mispredict counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 dec_valid  in  1  conditional branch leaving decode; enqueue request.
REQ-006 dec_pred  in  1  predictor output for that branch (1 = taken).
REQ-007 dec_target  in  32  taken-path address (PC + offset).
REQ-008 dec_fallthru  in  32  not-taken address (PC + 4).
REQ-009 res_valid  in  1  oldest branch resolved in MEM.
REQ-010 res_taken  in  1  actual branch decision.
REQ-011 upd_valid  out  1  one-cycle strobe that trains the predictor FSM.
REQ-012 upd_taken  out  1  outcome to train with; valid with upd_valid.
REQ-013 flush  out  1  squash younger pipeline stages.
REQ-014 redirect_pc  out  32  correct fetch address; valid while flush = 1.
REQ-015 full, empty  out  1 each  queue status.
REQ-016 mispredict_cnt  out  CNT_W  saturating mispredict count.
REQ-017 err_ovf, err_unf  out  1 each  sticky overflow/underflow flags.

Function
REQ-018 Queue SHALL be an in-order FIFO of {pred, target, fallthru}; enqueue on dec_valid, dequeue on res_valid, with no bypass.
REQ-019 FSM states SHALL be RUN and FLUSH; reset enters RUN.
REQ-020 In RUN, on res_valid with a non-empty queue, the head entry SHALL be compared against res_taken; mismatch = mispredict.
REQ-021 Every accepted resolve SHALL give upd_valid = 1 and upd_taken = res_taken in the next cycle, whether predicted correctly or not.
REQ-022 On mispredict in cycle N: in N+1 flush = 1 and redirect_pc = head.target if res_taken, else head.fallthru; the queue is emptied at the end of N; the FSM enters FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle (N+1), then return to RUN; flush is low in all other cycles.
REQ-024 dec_valid in cycles N and N+1 of a mispredict SHALL be discarded, since those instructions are squashed.
REQ-025 res_valid in FLUSH SHALL be ignored, with no update and no error.
REQ-026 Simultaneous enqueue and dequeue SHALL be legal at any occupancy, including full, and leave the count unchanged.
REQ-027 Enqueue when full without a dequeue SHALL drop the entry and set err_ovf.
REQ-028 res_valid when empty in RUN SHALL set err_unf and produce no upd_valid and no flush.
REQ-029 mispredict_cnt SHALL increment by 1 per mispredict, saturate at 2^CNT_W-1, and never wrap.
REQ-030 full = (count == DEPTH); empty = (count == 0); both derived from registered state.
REQ-031 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-032 On rst_n low: queue emptied, FSM = RUN, and upd_valid, upd_taken, flush, redirect_pc, mispredict_cnt, err_ovf and err_unf all reset to 0; empty = 1, full = 0.
REQ-033 Reset asserted mid-flush SHALL deassert flush immediately (asynchronously); the first cycle after release behaves as an idle RUN cycle.
REQ-034 Sticky error flags SHALL clear only on reset.

Structure
REQ-035 FSM state encodings and a queue-entry width constant (65 bits) SHALL be placed in the shared rv32i defines include.
REQ-036 The FIFO SHALL be the sub-module branch_fifo, with push/pop/clear ports; branch_resolve_ctrl holds the FSM, compare logic, counter and flags.
REQ-037 Branch predictor integration: upd_valid/upd_taken replace the predictor's registered MEM-stage branch signal and its actual-decision input.

Verification
REQ-038 Enqueue pred=1, target=0x100, fallthru=0x44; resolve res_taken=1 -> upd_valid=1, upd_taken=1, flush=0, cnt=0.
REQ-039 Enqueue pred=1, target=0x200, fallthru=0x84; resolve res_taken=0 -> next cycle flush=1, redirect_pc=0x84, cnt=1, empty=1; dec_valid in that cycle is discarded.
REQ-040 Fill 4 entries and push a 5th -> err_ovf=1, full=1; then pop and push in the same cycle -> count remains 4, err_ovf stays 1.
REQ-041 res_valid with the queue empty -> err_unf=1, upd_valid=0, flush=0.
REQ-042 CNT_W=2: five mispredicts -> mispredict_cnt=3 (saturated).
REQ-043 Pull rst_n low during the flush cycle -> flush drops without a clock edge; all outputs return to their reset values.
